// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module      : iterative_alu
// Description : 64-bit ALU with single-cycle add/sub/and/or and a bit-serial
//               left shift (one bit per clock). A three-state controller
//               (IDLE / SHIFT / DONE) sequences operations, raises busy while
//               the shift iterates and pulses done for one cycle on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  Operation,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] Result,
    output logic        Zero,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    // ------------------------------------------------------------------------
    // Operation encodings
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLL = 4'b1000;

    localparam logic [5:0] c_CNT_ZERO = 6'd0;
    localparam logic [5:0] c_CNT_ONE  = 6'd1;

    // ------------------------------------------------------------------------
    // Controller state encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Datapath registers: visible result, private shift accumulator and the
    // remaining-shift counter.
    logic [63:0] r_result;
    logic [63:0] r_acc;
    logic [5:0]  r_count;
    logic        r_illegal;

    // Decode helpers
    logic        w_accept;
    logic        w_is_sll;
    logic        w_sll_iter;
    logic        w_op_legal;
    logic [63:0] w_load_result;
    logic        w_shift_last;

    // A new operation may be accepted only from IDLE or DONE.
    assign w_accept     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_is_sll     = (Operation == c_OP_SLL);
    // A zero-length shift completes in one cycle like the logic ops, so only
    // a non-zero amount needs the iterative path.
    assign w_sll_iter   = w_is_sll && (b[5:0] != c_CNT_ZERO);
    assign w_shift_last = (r_count == c_CNT_ONE);

    // Single-cycle result selection; unsupported codes produce zero.
    always_comb begin
        w_load_result = 64'd0;
        w_op_legal    = 1'b1;
        case (Operation)
            c_OP_ADD: w_load_result = a + b;
            c_OP_SUB: w_load_result = a - b;
            c_OP_AND: w_load_result = a & b;
            c_OP_OR:  w_load_result = a | b;
            c_OP_SLL: w_load_result = a;
            default: begin
                w_load_result = 64'd0;
                w_op_legal    = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept from IDLE/DONE, iterate in SHIFT until the
    // final bit, and fall back to IDLE after a DONE with no new request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next_state = w_sll_iter ? S_SHIFT : S_DONE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_shift_last) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per SHIFT cycle, and publish
    // the accumulator to Result only on the last shift so Result keeps the
    // previous operation's value while the shift is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result  <= 64'd0;
            r_acc     <= 64'd0;
            r_count   <= c_CNT_ZERO;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_illegal <= ~w_op_legal;
            if (w_sll_iter) begin
                r_acc   <= a;
                r_count <= b[5:0];
            end else begin
                r_result <= w_load_result;
            end
        end else if (r_state == S_SHIFT) begin
            r_acc   <= r_acc << 1;
            r_count <= r_count - c_CNT_ONE;
            if (w_shift_last) begin
                r_result <= r_acc << 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Result  = r_result;
    assign Zero    = (r_result == 64'd0);
    assign busy    = (r_state == S_SHIFT);
    assign done    = (r_state == S_DONE);
    assign illegal = r_illegal && (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_alu
// Description : Directed self-checking bench for iterative_alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  Operation;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] Result;
    logic        Zero;
    logic        busy;
    logic        done;
    logic        illegal;

    int checks;
    int failures;

    iterative_alu dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Operation (Operation),
        .a         (a),
        .b         (b),
        .Result    (Result),
        .Zero      (Zero),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then release start and scramble inputs
    // so any late capture would be visible.
    task automatic issue(input logic [3:0] op, input logic [63:0] va, input logic [63:0] vb);
        Operation = op;
        a         = va;
        b         = vb;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        Operation = 4'b0001;
        a         = 64'h5A5A_5A5A_5A5A_5A5A;
        b         = 64'h0000_0000_0000_0007;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        Operation = 4'b0000;
        a         = 64'd0;
        b         = 64'd0;

        // Reset state
        tick();
        tick();
        chk("rst_result",  Result,  64'd0);
        chk("rst_zero",    Zero,    1'b1);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_done",    done,    1'b0);
        chk("rst_illegal", illegal, 1'b0);
        reset = 1'b0;
        tick();

        // add 5 + 7
        issue(4'b0010, 64'd5, 64'd7);
        chk("add_done",    done,    1'b1);
        chk("add_result",  Result,  64'd12);
        chk("add_zero",    Zero,    1'b0);
        chk("add_busy",    busy,    1'b0);
        chk("add_illegal", illegal, 1'b0);
        tick();
        chk("add_idle_done", done,   1'b0);
        chk("add_hold",      Result, 64'd12);

        // sub 9 - 9
        issue(4'b0110, 64'd9, 64'd9);
        chk("sub0_done",   done,   1'b1);
        chk("sub0_result", Result, 64'd0);
        chk("sub0_zero",   Zero,   1'b1);
        tick();

        // sub 0 - 1 wraps
        issue(4'b0110, 64'd0, 64'd1);
        chk("subw_result", Result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("subw_zero",   Zero,   1'b0);
        tick();

        // sll 1 << 4: busy after edges 0..3, done after edge 4
        issue(4'b1000, 64'd1, 64'd4);
        chk("sll4_busy0", busy,   1'b1);
        chk("sll4_done0", done,   1'b0);
        chk("sll4_hold",  Result, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("sll4_busy", busy, 1'b1);
            chk("sll4_nodone", done, 1'b0);
        end
        tick();
        chk("sll4_done",   done,   1'b1);
        chk("sll4_result", Result, 64'd16);
        chk("sll4_busyend", busy,  1'b0);
        tick();

        // sll by 0 completes in one cycle with Result = a
        issue(4'b1000, 64'h0000_0000_0000_ABCD, 64'd0);
        chk("sll0_done",   done,   1'b1);
        chk("sll0_busy",   busy,   1'b0);
        chk("sll0_result", Result, 64'h0000_0000_0000_ABCD);
        tick();

        // sll 1 << 63
        issue(4'b1000, 64'd1, 64'd63);
        for (int i = 1; i < 63; i++) begin
            tick();
            chk("sll63_busy", busy, 1'b1);
        end
        tick();
        chk("sll63_done",   done,   1'b1);
        chk("sll63_result", Result, 64'h8000_0000_0000_0000);
        tick();

        // start while busy is ignored
        issue(4'b1000, 64'd3, 64'd10);
        tick();
        tick();
        Operation = 4'b0010;
        a         = 64'd5;
        b         = 64'd7;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("ign_busy",   busy,   1'b1);
        chk("ign_done",   done,   1'b0);
        chk("ign_result", Result, 64'h8000_0000_0000_0000);
        for (int i = 4; i < 10; i++) begin
            tick();
            chk("ign_busy_run", busy, 1'b1);
        end
        tick();
        chk("ign_final_done",   done,   1'b1);
        chk("ign_final_result", Result, 64'd3072);
        tick();

        // back-to-back and -> or
        Operation = 4'b0000;
        a         = 64'hF0;
        b         = 64'h3C;
        start     = 1'b1;
        tick();
        chk("b2b_done1",   done,   1'b1);
        chk("b2b_result1", Result, 64'h30);
        Operation = 4'b0001;
        a         = 64'hF0;
        b         = 64'h0F;
        tick();
        start     = 1'b0;
        chk("b2b_done2",   done,   1'b1);
        chk("b2b_result2", Result, 64'hFF);
        tick();
        chk("b2b_idle", done, 1'b0);

        // reset during a shift aborts it
        issue(4'b1000, 64'd1, 64'd8);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy",   busy,   1'b0);
        chk("abort_done",   done,   1'b0);
        chk("abort_result", Result, 64'd0);
        chk("abort_zero",   Zero,   1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_nodone", done, 1'b0);
        end

        // unsupported operation
        issue(4'b1111, 64'd123, 64'd456);
        chk("ill_done",    done,    1'b1);
        chk("ill_illegal", illegal, 1'b1);
        chk("ill_result",  Result,  64'd0);
        tick();
        chk("ill_clear", illegal, 1'b0);

        // a legal op after an illegal one clears the flag
        issue(4'b0010, 64'd1, 64'd1);
        chk("leg_illegal", illegal, 1'b0);
        chk("leg_result",  Result,  64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request to begin an operation.
REQ-004 The block SHALL have the port Operation, input, 4 bits: the ALU control code (0010 add, 0110 sub, 0000 and, 0001 or, 1000 sll).
REQ-005 The block SHALL have the port a, input, 64 bits: operand A.
REQ-006 The block SHALL have the port b, input, 64 bits: operand B; for sll, b[5:0] is the shift amount.
REQ-007 The block SHALL have the port Result, output, 64 bits: the registered result.
REQ-008 The block SHALL have the port Zero, output, 1 bit: high when Result == 0.
REQ-009 The block SHALL have the port busy, output, 1 bit: high while a shift is iterating.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have the port illegal, output, 1 bit: high alongside done when the accepted Operation was unsupported.

Function
REQ-012 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-013 A start SHALL be accepted on a rising edge when the state is IDLE or DONE and start = 1.
REQ-014 Start SHALL be ignored while in SHIFT (busy = 1), with no effect on state or outputs.
REQ-015 On accept, a, b[5:0] and Operation SHALL be captured; later input changes SHALL have no effect until the next accept.
REQ-016 For add, sub, and or or, on the accept edge Result SHALL load the value: add a+b; sub a-b; and a&b; or a|b.
REQ-017 For add and sub, arithmetic SHALL be modulo 2^64, with no carry or overflow output.
REQ-018 For add, sub, and or or, the accept edge SHALL take the state to DONE (latency 1 cycle).
REQ-019 For sll with n = b[5:0] = 0, the accept edge SHALL load Result = a and take the state to DONE.
REQ-020 For sll with n ≥ 1, the accept edge SHALL load the accumulator with a and the count with n, and take the state to SHIFT.
REQ-021 On each SHIFT edge, the accumulator SHALL shift left by 1 with zero fill and the count SHALL decrement.
REQ-022 On the SHIFT edge where count = 1, the state SHALL go to DONE with Result = a << n; done SHALL therefore be seen n cycles after the accept edge.
REQ-023 For an unsupported Operation code, the accept edge SHALL load Result = 0 and go to DONE, with illegal = 1 for that DONE cycle.
REQ-024 done SHALL be 1 exactly in the DONE state.
REQ-025 In DONE, if start = 0 the next state SHALL be IDLE; if start = 1 a new operation SHALL be accepted back-to-back.
REQ-026 busy SHALL be 1 exactly in the SHIFT state.
REQ-027 Result SHALL hold its value through IDLE until the next accept.
REQ-028 Zero SHALL be combinational on the registered Result.
REQ-029 During SHIFT, Result SHALL hold the previous operation's value; the accumulator SHALL be internal.

Reset
REQ-030 With reset = 1 at a rising edge, the block SHALL go to state IDLE, with Result = 0, Zero = 1, busy = 0, done = 0, illegal = 0 and count = 0.
REQ-031 Reset SHALL take priority over start.
REQ-032 Reset asserted mid-SHIFT SHALL abort the operation and produce no done pulse.

Verification
REQ-033 The bench SHALL cover add: a=5, b=7, Operation=0010, start for 1 cycle -> next cycle done=1, Result=12, Zero=0, busy never 1.
REQ-034 The bench SHALL cover sub: a=9, b=9, Operation=0110 -> done after 1 cycle, Result=0, Zero=1; a=0, b=1 -> Result=0xFFFF_FFFF_FFFF_FFFF.
REQ-035 The bench SHALL cover sll: a=1, b=4, Operation=1000 -> busy=1 for cycles 1..3, done on cycle 4 with Result=16; b=0 -> done after 1 cycle, Result=a; b=63 -> done at cycle 63, Result=0x8000_0000_0000_0000.
REQ-036 The bench SHALL cover start while busy: sll a=3, b=10, then pulse start with add at cycle 3 -> add ignored, done at cycle 10 with Result=3072.
REQ-037 The bench SHALL cover back-to-back accept: hold start=1 with and a=0xF0, b=0x3C, then or a=0xF0, b=0x0F at the DONE cycle -> done on 2 consecutive cycles, Results 0x30 then 0xFF.
REQ-038 The bench SHALL cover reset and illegal: reset at cycle 2 of sll b=8 -> no done, Result=0, Zero=1, busy=0; then Operation=1111 -> done=1, illegal=1, Result=0.
